serial_subtractor_16bit: RTL and testbench

- Multi-cycle subtractor computing a - b - bin on 16-bit unsigned/two's-complement operands.
- Processes one 4-bit digit per clock with the borrow carried between cycles.
- Companion to the cascaded 4-bit-block adder in the arithmetic library: same datapath partitioning, inverse operation, time-multiplexed rather than spatially chained.
- Valid/ready handshake on both input and output so it can sit between pipeline stages of the datapath.

---
 rtl/serial_subtractor_16bit.sv | 122 ++++++++++++
 tb/tb_serial_subtractor_16bit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_16bit.sv
// Digit-serial subtractor: computes a - b - bin one DIGIT-wide slice per clock,
// rippling the borrow through a register, with valid/ready handshakes on both sides.
module serial_subtractor_16bit #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf,
    output logic             zero,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [DIGIT:0]   dig_sub;

    // NOTE: synchronous reset inside the clocked block; every register, operand copies included, is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    // NOTE: every signal gets a hold-value default first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        // Extra MSB of the widened difference is the digit's borrow-out.
        dig_sub = {1'b0, a_q[cnt_q*DIGIT +: DIGIT]}
                - {1'b0, b_q[cnt_q*DIGIT +: DIGIT]}
                - {{DIGIT{1'b0}}, borrow_q};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = bin;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                diff_d[cnt_q*DIGIT +: DIGIT] = dig_sub[DIGIT-1:0];
                borrow_d = dig_sub[DIGIT];
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    bout_d  = dig_sub[DIGIT];
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                              (diff_d[WIDTH-1] != a_q[WIDTH-1]);
                    zero_d  = (diff_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor_16bit.sv
// Self-checking bench: arithmetic reference model compared every cycle, plus
// directed vectors with hand-computed results, backpressure and mid-operation reset.
module tb_serial_subtractor_16bit;

    localparam int WIDTH = 16;
    localparam int N     = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a, b;
    logic             bin, in_valid, out_ready;
    logic             in_ready, bout, ovf, zero, out_valid;
    logic [WIDTH-1:0] diff;

    int  pass_cnt  = 0;
    int  total_cnt = 0;
    bit  chk_en    = 1'b0;

    typedef struct packed {
        logic [WIDTH-1:0] diff;
        logic             bout;
        logic             ovf;
        logic             zero;
    } res_t;

    res_t m_res, m_pend;
    int   m_cnt;
    bit   m_busy, m_valid;

    serial_subtractor_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .bout      (bout),
        .ovf       (ovf),
        .zero      (zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference result from plain integer arithmetic on the operands.
    function automatic res_t ref_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                     input logic bi);
        res_t        r;
        logic [16:0] w;
        int          s;
        w      = {1'b0, x} - {1'b0, y} - {16'd0, bi};
        s      = int'($signed(x)) - int'($signed(y)) - int'(bi);
        r.diff = w[15:0];
        r.bout = w[16];
        r.ovf  = (s < -32768) || (s > 32767);
        r.zero = (w[15:0] == 16'h0);
        return r;
    endfunction

    // Transaction-level model: accepted op becomes visible N edges later, held until taken.
    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
            m_res   = '0;
        end else if (m_valid) begin
            if (out_ready) m_valid = 1'b0;
        end else if (m_busy) begin
            m_cnt--;
            if (m_cnt == 0) begin
                m_busy  = 1'b0;
                m_valid = 1'b1;
                m_res   = m_pend;
            end
        end else if (in_valid) begin
            m_busy = 1'b1;
            m_cnt  = N;
            m_pend = ref_sub(a, b, bin);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", 32'(in_ready), 32'(!(m_busy || m_valid)));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (!m_busy) begin
                check("model_diff", 32'(diff), 32'(m_res.diff));
                check("model_bout", 32'(bout), 32'(m_res.bout));
                check("model_ovf", 32'(ovf), 32'(m_res.ovf));
                check("model_zero", 32'(zero), 32'(m_res.zero));
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          input logic [15:0] e_diff, input logic e_bout, input logic e_ovf,
                          input logic e_zero, input int hold);
        int lat;
        a = ta; b = tb; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
            a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom); in_valid = 1'($urandom);
        end
        check("latency", 32'(lat), 32'(N));
        check("lit_diff", 32'(diff), 32'(e_diff));
        check("lit_bout", 32'(bout), 32'(e_bout));
        check("lit_ovf", 32'(ovf), 32'(e_ovf));
        check("lit_zero", 32'(zero), 32'(e_zero));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a = 16'($urandom); b = 16'($urandom); in_valid = 1'($urandom);
        end
        if (hold > 0) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_diff", 32'(diff), 32'(e_diff));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b1; a = '0; b = '0; bin = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);

        run_op(16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0, 1'b0, 10);
        run_op(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 0);
        run_op(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 2);
        run_op(16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0);
        run_op(16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1);
        run_op(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 0);

        // Reset on the second CALC cycle abandons the operation.
        a = 16'hABCD; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        repeat (6) @(negedge clk);
        check("midrst_noresult", 32'(out_valid), 32'd0);

        run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, 1'b0, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
